pwm_bank: RTL
=============

// Module: pwm_bank
// PURPOSE
//  Parametrised multi-channel PWM peripheral on the CPU memory-store bus (addr[31:29] selects destination).
//  Generalises the single-channel PWM: CHANNELS outputs, per-channel period/duty/mode, shared prescaler.
//  Adds shadowed registers reloaded at the period boundary, centre-aligned mode, output invert and readback.
//  Sits beside ram in the memory stage; CPU stores program it and loads read it.
// PARAMETERS
//  CHANNELS   4       number of PWM outputs (1..8)
//  CNT_WIDTH  16      width of period, duty and channel counters
//  PRE_WIDTH  8       width of the shared prescaler
//  PERIPH_ID  3'b001  value of addr[31:29] that selects this block
// PORTS
//  clk          in   1          system clock
//  rst          in   1          asynchronous, active-low reset
//  addr         in   32         byte address; [31:29]=PERIPH_ID selects, [7:2]=word offset
//  data_in      in   32         store data
//  write_enable in   1          store strobe, one cycle per access
//  read_enable  in   1          load strobe, one cycle per access
//  data_out     out  32         load data, registered
//  read_valid   out  1          data_out valid, 1 cycle after read_enable
//  pwm_out      out  CHANNELS   PWM outputs, registered
// BEHAVIOUR
//  Selected access: addr[31:29]==PERIPH_ID. Unselected or unmapped-offset writes are ignored; reads return 0.
//  Map (word offset): 0 CTRL [0]=global en, [1+c]=channel c en; 1 PRESCALE [PRE_WIDTH-1:0];
//   4+4c PERIOD_c, 5+4c DUTY_c, 6+4c MODE_c ([0]=centre-aligned, [1]=invert), 7+4c COUNT_c (read-only).
//  Writes to PERIOD/DUTY/MODE land in pending regs; reads return pending values. Upper data bits are truncated.
//  Read: data_out and read_valid update on the clock edge after read_enable; otherwise read_valid=0 and data_out holds.
//  Simultaneous read and write to the same register: the read returns the pre-write value.
//  Prescaler: counts 0..PRESCALE while global en=1; tick=1 when it equals PRESCALE, then it wraps to 0.
//   PRESCALE=0 gives a tick every cycle. Global en=0 holds the prescaler at 0.
//  Channel active (global en & channel en): counter advances only on tick.
//   Edge mode: 0,1,..,PERIOD,0,... Boundary is the tick at count==PERIOD.
//   Centre mode: 0 up to PERIOD, then down to 1, then 0,... (period 2*PERIOD ticks). Boundary is the tick at count==1 counting down.
//   PERIOD=0 in either mode: counter stays 0 and every tick is a boundary.
//  Reload: at a boundary, active period/duty/mode <= pending values and the counter restarts at 0 with direction up.
//   A write in the same cycle as a boundary is applied at the next boundary.
//  Inactive channel: counter held at 0, direction up, active regs track pending every cycle.
//  Compare: raw = active & (count < active duty). DUTY=0 gives constant low; DUTY>PERIOD gives constant high.
//  pwm_out[c] <= raw ^ invert. This adds 1 cycle of latency after the counter; an inactive channel outputs the invert bit.
//  COUNT_c read returns the live counter, zero-extended.
//  Reset (rst=0, any time, async): all regs, counters, prescaler, data_out, read_valid and pwm_out go to 0.
//   Operation resumes from the all-disabled state after rst returns to 1.
// TESTING
//  1 Run ch0 at PERIOD=9, DUTY=3, then drop rst mid-period -> pwm_out=0, data_out=0, read_valid=0 in the same cycle; CTRL reads 0 after release.
//  2 PRESCALE=0, PERIOD_0=9, DUTY_0=3, CTRL=3 -> pwm_out[0] is high 3 cycles and low 7, repeating every 10 cycles.
//  3 As in scenario 2, write DUTY_0=7 at count 5 -> the current period stays 3 high; the next period is 7 high/3 low; a DUTY_0 read returns 7 immediately.
//  4 MODE_0=1, PERIOD_0=4, DUTY_0=2 -> COUNT sequence 0,1,2,3,4,3,2,1; pwm_out[0] is high 3 of 8 cycles.
//  5 Set DUTY=0 (constant low) and DUTY=10 with PERIOD=9 (constant high), then MODE[1]=1 -> outputs invert; a disabled channel idles at the invert bit.
//  6 PRESCALE=3, PERIOD=9 -> period is 40 cycles; a write with addr[31:29]=3'b000 is ignored; reading offset 0x3F gives 0 with read_valid=1.

Source files
------------

// File: rtl/pwm_bank_if.sv
// Memory-stage store/load bus between the CPU and the PWM bank.
// The CPU side drives addresses and strobes; the peripheral returns registered load data.
interface pwm_bank_if;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic        write_enable;
    logic        read_enable;
    logic [31:0] data_out;
    logic        read_valid;

    modport master (
        output addr,
        output data_in,
        output write_enable,
        output read_enable,
        input  data_out,
        input  read_valid
    );

    modport slave (
        input  addr,
        input  data_in,
        input  write_enable,
        input  read_enable,
        output data_out,
        output read_valid
    );
endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank with a shared prescaler and per-channel period/duty/mode.
// Pending registers take CPU writes; active copies reload at each channel's period boundary.
module pwm_bank #(
    parameter int         CHANNELS  = 4,
    parameter int         CNT_WIDTH = 16,
    parameter int         PRE_WIDTH = 8,
    parameter logic [2:0] PERIPH_ID = 3'b001
) (
    input  logic                clk,
    input  logic                rst,
    pwm_bank_if.slave           bus,
    output logic [CHANNELS-1:0] pwm_out
);
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    localparam cnt_t                 CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam cnt_t                 CNT_ONE  = cnt_t'(1'b1);
    localparam logic [PRE_WIDTH-1:0] PRE_ZERO = {PRE_WIDTH{1'b0}};
    localparam logic [PRE_WIDTH-1:0] PRE_ONE  = PRE_WIDTH'(1'b1);

    logic [CHANNELS:0]    ctrl_q, ctrl_d;
    logic [PRE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;

    cnt_t       period_pend_q [CHANNELS];
    cnt_t       period_pend_d [CHANNELS];
    cnt_t       duty_pend_q   [CHANNELS];
    cnt_t       duty_pend_d   [CHANNELS];
    logic [1:0] mode_pend_q   [CHANNELS];
    logic [1:0] mode_pend_d   [CHANNELS];
    cnt_t       period_act_q  [CHANNELS];
    cnt_t       period_act_d  [CHANNELS];
    cnt_t       duty_act_q    [CHANNELS];
    cnt_t       duty_act_d    [CHANNELS];
    logic [1:0] mode_act_q    [CHANNELS];
    logic [1:0] mode_act_d    [CHANNELS];
    cnt_t       cnt_q         [CHANNELS];
    cnt_t       cnt_d         [CHANNELS];

    logic [CHANNELS-1:0] down_q, down_d;
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic [CHANNELS-1:0] active_s, bnd_s;

    logic [31:0] data_out_q, data_out_d;
    logic        read_valid_q, read_valid_d;

    logic        sel_s, wr_s, tick_s, ch_hit_s;
    logic [5:0]  off_s, ch_off_s;
    logic [3:0]  ch_idx_s;
    logic [1:0]  sub_s;
    logic [31:0] rdata_s;
    logic        unused_s;

    assign sel_s    = (bus.addr[31:29] == PERIPH_ID);
    assign off_s    = bus.addr[7:2];
    assign ch_off_s = off_s - 6'd4;
    assign ch_idx_s = ch_off_s[5:2];
    assign sub_s    = ch_off_s[1:0];
    assign ch_hit_s = (off_s >= 6'd4) && (int'(ch_idx_s) < CHANNELS);
    assign wr_s     = sel_s && bus.write_enable;
    assign tick_s   = ctrl_q[0] && (pre_cnt_q == prescale_q);
    assign unused_s = ^{bus.addr[28:8], bus.addr[1:0], bus.data_in};

    // Load data mux: pending values, control, prescale and live counters
    always_comb begin
        rdata_s = 32'd0;
        if (!sel_s) begin
            rdata_s = 32'd0;
        end else if (off_s == 6'd0) begin
            rdata_s[CHANNELS:0] = ctrl_q;
        end else if (off_s == 6'd1) begin
            rdata_s[PRE_WIDTH-1:0] = prescale_q;
        end else if (ch_hit_s) begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (ch_idx_s == 4'(c)) begin
                    case (sub_s)
                        2'd0:    rdata_s[CNT_WIDTH-1:0] = period_pend_q[c];
                        2'd1:    rdata_s[CNT_WIDTH-1:0] = duty_pend_q[c];
                        2'd2:    rdata_s[1:0]           = mode_pend_q[c];
                        2'd3:    rdata_s[CNT_WIDTH-1:0] = cnt_q[c];
                        default: rdata_s                = 32'd0;
                    endcase
                end else begin
                    rdata_s = rdata_s;
                end
            end
        end else begin
            rdata_s = 32'd0;
        end
    end

    // Store decode for control, prescale and the pending channel registers
    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        if (wr_s && (off_s == 6'd0)) begin
            ctrl_d = bus.data_in[CHANNELS:0];
        end else if (wr_s && (off_s == 6'd1)) begin
            prescale_d = bus.data_in[PRE_WIDTH-1:0];
        end else begin
            ctrl_d     = ctrl_q;
            prescale_d = prescale_q;
        end
        for (int c = 0; c < CHANNELS; c++) begin
            period_pend_d[c] = period_pend_q[c];
            duty_pend_d[c]   = duty_pend_q[c];
            mode_pend_d[c]   = mode_pend_q[c];
            if (wr_s && ch_hit_s && (ch_idx_s == 4'(c))) begin
                case (sub_s)
                    2'd0:    period_pend_d[c] = bus.data_in[CNT_WIDTH-1:0];
                    2'd1:    duty_pend_d[c]   = bus.data_in[CNT_WIDTH-1:0];
                    2'd2:    mode_pend_d[c]   = bus.data_in[1:0];
                    default: mode_pend_d[c]   = mode_pend_q[c];
                endcase
            end else begin
                mode_pend_d[c] = mode_pend_q[c];
            end
        end
    end

    // Shared prescaler: wraps after reaching PRESCALE, held at zero while globally disabled
    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (!ctrl_q[0]) begin
            pre_cnt_d = PRE_ZERO;
        end else if (tick_s) begin
            pre_cnt_d = PRE_ZERO;
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_ONE;
        end
    end

    // Per-channel activity and period-boundary detection
    always_comb begin
        active_s = {CHANNELS{1'b0}};
        bnd_s    = {CHANNELS{1'b0}};
        for (int c = 0; c < CHANNELS; c++) begin
            active_s[c] = ctrl_q[0] & ctrl_q[c+1];
            // Centre mode with PERIOD=1 never turns round, so count==1 going up also ends it
            bnd_s[c] = (period_act_q[c] == CNT_ZERO)
                    || (!mode_act_q[c][0] && (cnt_q[c] == period_act_q[c]))
                    || (mode_act_q[c][0] && (cnt_q[c] == CNT_ONE)
                        && (down_q[c] || (period_act_q[c] == CNT_ONE)));
        end
    end

    // Channel counters, direction, active-register reload and compare
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            cnt_d[c]        = cnt_q[c];
            down_d[c]       = down_q[c];
            period_act_d[c] = period_act_q[c];
            duty_act_d[c]   = duty_act_q[c];
            mode_act_d[c]   = mode_act_q[c];
            if (!active_s[c] || (tick_s && bnd_s[c])) begin
                cnt_d[c]        = CNT_ZERO;
                down_d[c]       = 1'b0;
                period_act_d[c] = period_pend_q[c];
                duty_act_d[c]   = duty_pend_q[c];
                mode_act_d[c]   = mode_pend_q[c];
            end else if (!tick_s) begin
                cnt_d[c] = cnt_q[c];
            end else if (down_q[c]) begin
                cnt_d[c] = cnt_q[c] - CNT_ONE;
            end else if (mode_act_q[c][0] && (cnt_q[c] == period_act_q[c])) begin
                down_d[c] = 1'b1;
                cnt_d[c]  = cnt_q[c] - CNT_ONE;
            end else begin
                cnt_d[c] = cnt_q[c] + CNT_ONE;
            end
            pwm_d[c] = (active_s[c] && (cnt_q[c] < duty_act_q[c])) ^ mode_act_q[c][1];
        end
    end

    // Load response: valid for one cycle after a load, data held otherwise
    always_comb begin
        read_valid_d = bus.read_enable;
        if (bus.read_enable) begin
            data_out_d = rdata_s;
        end else begin
            data_out_d = data_out_q;
        end
    end

    // Global state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q       <= {(CHANNELS+1){1'b0}};
            prescale_q   <= PRE_ZERO;
            pre_cnt_q    <= PRE_ZERO;
            down_q       <= {CHANNELS{1'b0}};
            pwm_q        <= {CHANNELS{1'b0}};
            data_out_q   <= 32'd0;
            read_valid_q <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            prescale_q   <= prescale_d;
            pre_cnt_q    <= pre_cnt_d;
            down_q       <= down_d;
            pwm_q        <= pwm_d;
            data_out_q   <= data_out_d;
            read_valid_q <= read_valid_d;
        end
    end

    // Per-channel register arrays
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                period_pend_q[c] <= CNT_ZERO;
                duty_pend_q[c]   <= CNT_ZERO;
                mode_pend_q[c]   <= 2'b00;
                period_act_q[c]  <= CNT_ZERO;
                duty_act_q[c]    <= CNT_ZERO;
                mode_act_q[c]    <= 2'b00;
                cnt_q[c]         <= CNT_ZERO;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                period_pend_q[c] <= period_pend_d[c];
                duty_pend_q[c]   <= duty_pend_d[c];
                mode_pend_q[c]   <= mode_pend_d[c];
                period_act_q[c]  <= period_act_d[c];
                duty_act_q[c]    <= duty_act_d[c];
                mode_act_q[c]    <= mode_act_d[c];
                cnt_q[c]         <= cnt_d[c];
            end
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.read_valid = read_valid_q;
    assign pwm_out        = pwm_q;
endmodule
